// File: rtl/register_file_master_if.sv
// Bus bundle between the frame parser (master side) and its serial link / register file (slave side).
interface register_file_master_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_data_valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write_enable;
    logic                     read_enable;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     read_data_valid;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic                     tx_data_valid;
    logic                     tx_ready;
    logic                     error;

    modport master (
        input  rx_data, rx_data_valid, read_data, read_data_valid, tx_ready,
        output address, write_enable, read_enable, write_data, tx_data, tx_data_valid, error
    );

    modport slave (
        output rx_data, rx_data_valid, read_data, read_data_valid, tx_ready,
        input  address, write_enable, read_enable, write_data, tx_data, tx_data_valid, error
    );
endinterface

// File: rtl/register_file_master.sv
// Byte-serial command frame parser driving register_file write/read strobes and returning read bytes.
// Optional READ_TIMEOUT_EN: abandon a read after TIMEOUT_CYCLES cycles without read_data_valid.
module register_file_master #(
    parameter int                    DATA_WIDTH          = 8,
    parameter int                    REGISTER_FILE_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] WRITE_CMD           = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] READ_CMD            = 8'hBB,
    parameter int                    TIMEOUT_CYCLES      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    register_file_master_if.master bus
);
    localparam int ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    // The 8-bit timeout counter bounds TIMEOUT_CYCLES; address must fit inside a frame byte.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256 || ADDRESS_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("register_file_master: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_ISSUE, RD_ADDR, RD_ISSUE, RD_WAIT, TX_HOLD
    } state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] address_q, address_next;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_next;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_next;
    logic                     write_enable_q, write_enable_next;
    logic                     read_enable_q, read_enable_next;
    logic                     tx_data_valid_q, tx_data_valid_next;
    logic                     error_q, error_next;
    logic                     address_bad;

`ifdef READ_TIMEOUT_EN
    logic [7:0] timeout_count, timeout_count_next;
`endif

    assign address_bad = (bus.rx_data >> ADDRESS_WIDTH) != '0;

    always_comb begin
        state_next         = state;
        address_next       = address_q;
        write_data_next    = write_data_q;
        tx_data_next       = tx_data_q;
        write_enable_next  = 1'b0;
        read_enable_next   = 1'b0;
        tx_data_valid_next = tx_data_valid_q;
        error_next         = 1'b0;
`ifdef READ_TIMEOUT_EN
        timeout_count_next = timeout_count;
`endif
        case (state)
            IDLE: begin
                if (bus.rx_data_valid) begin
                    if (bus.rx_data == WRITE_CMD)     state_next = WR_ADDR;
                    else if (bus.rx_data == READ_CMD) state_next = RD_ADDR;
                    else                              error_next = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (bus.rx_data_valid) begin
                    address_next = bus.rx_data[ADDRESS_WIDTH-1:0];
                    if (address_bad) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else if (state == WR_ADDR) begin
                        state_next = WR_DATA;
                    end else begin
                        read_enable_next = 1'b1;
                        state_next       = RD_ISSUE;
                    end
                end
            end
            WR_DATA: begin
                if (bus.rx_data_valid) begin
                    write_data_next   = bus.rx_data;
                    write_enable_next = 1'b1;
                    state_next        = WR_ISSUE;
                end
            end
            // From here on a transaction is in flight: stray bytes are dropped and flagged.
            WR_ISSUE: begin
                error_next = bus.rx_data_valid;
                state_next = IDLE;
            end
            RD_ISSUE: begin
                error_next = bus.rx_data_valid;
                state_next = RD_WAIT;
`ifdef READ_TIMEOUT_EN
                timeout_count_next = 8'd0;
`endif
            end
            RD_WAIT: begin
                error_next = bus.rx_data_valid;
                if (bus.read_data_valid) begin
                    tx_data_next       = bus.read_data;
                    tx_data_valid_next = 1'b1;
                    state_next         = TX_HOLD;
                end
`ifdef READ_TIMEOUT_EN
                else if (timeout_count == 8'(TIMEOUT_CYCLES - 1)) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    timeout_count_next = timeout_count + 8'd1;
                end
`endif
            end
            TX_HOLD: begin
                error_next = bus.rx_data_valid;
                if (bus.tx_ready) begin
                    tx_data_valid_next = 1'b0;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            address_q       <= '0;
            write_data_q    <= '0;
            tx_data_q       <= '0;
            write_enable_q  <= 1'b0;
            read_enable_q   <= 1'b0;
            tx_data_valid_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state           <= state_next;
            address_q       <= address_next;
            write_data_q    <= write_data_next;
            tx_data_q       <= tx_data_next;
            write_enable_q  <= write_enable_next;
            read_enable_q   <= read_enable_next;
            tx_data_valid_q <= tx_data_valid_next;
            error_q         <= error_next;
        end
    end

`ifdef READ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_count <= 8'd0;
        else        timeout_count <= timeout_count_next;
    end
`endif

    assign bus.address       = address_q;
    assign bus.write_data    = write_data_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.read_enable   = read_enable_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.error         = error_q;
endmodule

// File: tb/tb_register_file_master.sv
// Scoreboard bench for register_file_master with a behavioural register file on the slave side.
module tb_register_file_master;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    register_file_master #(
        .DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(DEPTH), .WRITE_CMD(8'hAA),
        .READ_CMD(8'hBB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Register file model: write on strobe, answer a read one cycle after read_enable.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rf_rdata;
    logic          rf_valid;
    logic          rf_mute;
    always @(posedge clk) begin
        rf_valid <= bus.read_enable && !rf_mute;
        if (bus.read_enable) rf_rdata <= mem[bus.address];
        if (bus.write_enable) mem[bus.address] <= bus.write_data;
    end
    assign bus.read_data       = rf_rdata;
    assign bus.read_data_valid = rf_valid;

    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] tx_q[$];
    int total = 0, bad = 0;
    int wr_seen = 0, rd_seen = 0, tx_seen = 0, err_seen = 0;

    // Scoreboard sampling of the values present at the upcoming edge, then advance one cycle.
    task automatic tick();
        wr_t           e;
        logic [AW-1:0] ra;
        logic [DW-1:0] td;
        if (bus.write_enable === 1'b1) begin
            wr_seen++;
            total++;
            if (bus.read_enable !== 1'b0) begin
                bad++;
                $display("FAIL strobe_overlap: read_enable=%b while write_enable=1, required 0", bus.read_enable);
            end
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: address=%0h data=%0h, required no strobe", bus.address, bus.write_data);
            end else begin
                e = wr_q.pop_front();
                if ({bus.address, bus.write_data} !== {e.a, e.d}) begin
                    bad++;
                    $display("FAIL write_beat: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             bus.address, bus.write_data, e.a, e.d);
                end
            end
        end
        if (bus.read_enable === 1'b1) begin
            rd_seen++;
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: address=%0h, required no strobe", bus.address);
            end else begin
                ra = rd_q.pop_front();
                if (bus.address !== ra) begin
                    bad++;
                    $display("FAIL read_addr: got %0h, required %0h", bus.address, ra);
                end
            end
        end
        if (bus.tx_data_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            tx_seen++;
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tx: tx_data=%0h, required none", bus.tx_data);
            end else begin
                td = tx_q.pop_front();
                if (bus.tx_data !== td) begin
                    bad++;
                    $display("FAIL tx_byte: got %0h, required %0h", bus.tx_data, td);
                end
            end
        end
        if (bus.error === 1'b1) err_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        tick();
        bus.rx_data_valid = 1'b0;
    endtask

    task automatic wait_tx_valid(input string name);
        int n;
        n = 0;
        while (bus.tx_data_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (bus.tx_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: tx_data_valid=%b after %0d cycles, required 1", name, bus.tx_data_valid, n);
        end
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        bus.rx_data       = '0;
        bus.rx_data_valid = 1'b0;
        bus.tx_ready      = 1'b1;
        rf_mute           = 1'b0;
        idle(2);
        total++;
        if ({bus.address, bus.write_data, bus.tx_data} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0h wdata=%0h tx=%0h, required 0", bus.address, bus.write_data, bus.tx_data);
        end
        total++;
        if ({bus.write_enable, bus.read_enable, bus.tx_data_valid, bus.error} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: we/re/txv/err=%b, required 0000",
                     {bus.write_enable, bus.read_enable, bus.tx_data_valid, bus.error});
        end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        int w0, e0, t0;
        w0 = wr_seen; e0 = err_seen; t0 = tx_seen;
        wr_q.push_back('{a: 4'h5, d: 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        total++;
        if ({bus.write_enable, bus.address, bus.write_data} !== {1'b1, 4'h5, 8'h3C}) begin
            bad++;
            $display("FAIL write_latency: we=%b addr=%0h data=%0h, required 1/5/3c",
                     bus.write_enable, bus.address, bus.write_data);
        end
        tick();
        total++;
        if (bus.write_enable !== 1'b0) begin
            bad++;
            $display("FAIL write_pulse_width: we=%b, required 0", bus.write_enable);
        end
        idle(2);
        rd_q.push_back(4'h5);
        tx_q.push_back(8'h3C);
        send_byte(8'hBB); send_byte(8'h05);
        idle(6);
        total++;
        if (wr_seen - w0 !== 1 || tx_seen - t0 !== 1 || err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL write_then_read: writes=%0d tx=%0d errors=%0d, required 1/1/0",
                     wr_seen - w0, tx_seen - t0, err_seen - e0);
        end
    endtask

    task automatic test_read_hold();
        int t0;
        wr_q.push_back('{a: 4'h2, d: 8'hF4});
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'hF4);
        idle(2);
        t0 = tx_seen;
        bus.tx_ready = 1'b0;
        rd_q.push_back(4'h2);
        tx_q.push_back(8'hF4);
        send_byte(8'hBB); send_byte(8'h02);
        total++;
        if ({bus.read_enable, bus.write_enable, bus.address} !== {1'b1, 1'b0, 4'h2}) begin
            bad++;
            $display("FAIL read_strobe: re=%b we=%b addr=%0h, required 1/0/2", bus.read_enable, bus.write_enable, bus.address);
        end
        wait_tx_valid("read_response");
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.tx_data_valid, bus.tx_data} !== {1'b1, 8'hF4}) begin
                bad++;
                $display("FAIL tx_hold: cycle %0d txv=%b tx=%0h, required 1/f4", i, bus.tx_data_valid, bus.tx_data);
            end
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        total++;
        if (bus.tx_data_valid !== 1'b0 || tx_seen - t0 !== 1) begin
            bad++;
            $display("FAIL tx_accept: txv=%b transfers=%0d, required 0/1", bus.tx_data_valid, tx_seen - t0);
        end
    endtask

    task automatic test_bad_frames();
        int w0, e0;
        w0 = wr_seen; e0 = err_seen;
        send_byte(8'h7E);
        idle(2);
        total++;
        if (err_seen - e0 !== 1 || wr_seen - w0 !== 0) begin
            bad++;
            $display("FAIL bad_cmd: errors=%0d writes=%0d, required 1/0", err_seen - e0, wr_seen - w0);
        end
        e0 = err_seen;
        send_byte(8'hAA); send_byte(8'h10);
        idle(3);
        total++;
        if (err_seen - e0 !== 1 || wr_seen - w0 !== 0) begin
            bad++;
            $display("FAIL bad_addr: errors=%0d writes=%0d, required 1/0", err_seen - e0, wr_seen - w0);
        end
        e0 = err_seen;
        wr_q.push_back('{a: 4'hF, d: 8'h7D});
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h7D);
        idle(3);
        total++;
        if (err_seen - e0 !== 0 || wr_seen - w0 !== 1) begin
            bad++;
            $display("FAIL top_addr: errors=%0d writes=%0d, required 0/1", err_seen - e0, wr_seen - w0);
        end
    endtask

    task automatic test_overrun();
        int w0, e0;
        bus.tx_ready = 1'b0;
        rd_q.push_back(4'h2);
        tx_q.push_back(8'hF4);
        send_byte(8'hBB); send_byte(8'h02);
        wait_tx_valid("overrun_response");
        e0 = err_seen;
        send_byte(8'h11);
        tick();
        total++;
        if (err_seen - e0 !== 1 || {bus.tx_data_valid, bus.tx_data} !== {1'b1, 8'hF4}) begin
            bad++;
            $display("FAIL tx_overrun: errors=%0d txv=%b tx=%0h, required 1/1/f4", err_seen - e0, bus.tx_data_valid, bus.tx_data);
        end
        bus.tx_ready = 1'b1;
        tick();
        w0 = wr_seen; e0 = err_seen;
        wr_q.push_back('{a: 4'h1, d: 8'h55});
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55);
        send_byte(8'h5A);
        idle(3);
        total++;
        if (wr_seen - w0 !== 1 || err_seen - e0 !== 1) begin
            bad++;
            $display("FAIL issue_overrun: writes=%0d errors=%0d, required 1/1", wr_seen - w0, err_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        int w0, e0;
        w0 = wr_seen; e0 = err_seen;
        wr_q.push_back('{a: 4'h6, d: 8'hA1});
        wr_q.push_back('{a: 4'h7, d: 8'hB2});
        send_byte(8'hAA); send_byte(8'h06); send_byte(8'hA1);
        tick();
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'hB2);
        idle(3);
        total++;
        if (wr_seen - w0 !== 2 || err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL back_to_back: writes=%0d errors=%0d, required 2/0", wr_seen - w0, err_seen - e0);
        end
    endtask

    task automatic test_mid_frame_reset();
        int w0, e0;
        send_byte(8'hAA); send_byte(8'h03);
        reset = 1'b0;
        #2;
        total++;
        if ({bus.address, bus.write_data, bus.tx_data, bus.write_enable, bus.read_enable,
             bus.tx_data_valid, bus.error} !== '0) begin
            bad++;
            $display("FAIL async_reset: addr=%0h wdata=%0h tx=%0h ctrl=%b, required all 0", bus.address,
                     bus.write_data, bus.tx_data, {bus.write_enable, bus.read_enable, bus.tx_data_valid, bus.error});
        end
        tick();
        reset = 1'b1;
        tick();
        w0 = wr_seen; e0 = err_seen;
        send_byte(8'h99);
        idle(3);
        total++;
        if (wr_seen - w0 !== 0 || err_seen - e0 !== 1) begin
            bad++;
            $display("FAIL frame_discard: writes=%0d errors=%0d, required 0/1", wr_seen - w0, err_seen - e0);
        end
        wr_q.push_back('{a: 4'h3, d: 8'h99});
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h99);
        idle(3);
        total++;
        if (wr_seen - w0 !== 1) begin
            bad++;
            $display("FAIL reframe_write: writes=%0d, required 1", wr_seen - w0);
        end
    endtask

`ifdef READ_TIMEOUT_EN
    task automatic test_timeout();
        int n, t0;
        logic tx_seen_high;
        t0 = tx_seen;
        tx_seen_high = 1'b0;
        rf_mute = 1'b1;
        rd_q.push_back(4'h1);
        send_byte(8'hBB); send_byte(8'h01);
        n = 0;
        while (bus.error !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (bus.tx_data_valid === 1'b1) tx_seen_high = 1'b1;
        end
        total++;
        if (n !== TO + 1 || tx_seen_high !== 1'b0) begin
            bad++;
            $display("FAIL read_timeout: error after %0d cycles txv_seen=%b, required %0d/0", n, tx_seen_high, TO + 1);
        end
        rf_mute = 1'b0;
        idle(3);
        total++;
        if (tx_seen - t0 !== 0) begin
            bad++;
            $display("FAIL timeout_no_tx: transfers=%0d, required 0", tx_seen - t0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_bad_frames();
        test_overrun();
        test_back_to_back();
        test_mid_frame_reset();
`ifdef READ_TIMEOUT_EN
        test_timeout();
`endif
        idle(3);
        total++;
        if (wr_q.size() + rd_q.size() + tx_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending wr=%0d rd=%0d tx=%0d, required 0", wr_q.size(), rd_q.size(), tx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
